// File: rtl/mul_div_unit.sv
// Iterative 32x32 multiply / divide unit for the integer pipeline.
// MULT/MULTU use a radix-2 shift-add over 32 cycles, DIV/DIVU a restoring
// shift-subtract over 32 cycles; one extra FIX cycle applies sign correction.
module mul_div_unit (
    input  logic        clk,
    input  logic        resetN,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] srcA,
    input  logic [31:0] srcB,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] lo,
    output logic [31:0] hi
);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t      state;
    logic        isDiv;
    logic        aNeg;
    logic        bNeg;
    logic        divZero;
    logic [31:0] magA;
    logic [31:0] magB;
    logic [5:0]  count;
    logic [63:0] acc;

    // Operand conditioning at start: signed ops work on magnitudes.
    logic        opSigned;
    logic [31:0] absA;
    logic [31:0] absB;
    assign opSigned = ~op[0];
    assign absA     = (opSigned && srcA[31]) ? -srcA : srcA;
    assign absB     = (opSigned && srcB[31]) ? -srcB : srcB;

    // One iteration step; operand bits are consumed MSB first.
    logic [4:0]  bitIdx;
    logic [63:0] mulStep;
    logic [32:0] remShift;
    logic [32:0] remDiff;
    logic [63:0] divStep;
    assign bitIdx   = ~count[4:0];
    assign mulStep  = {acc[62:0], 1'b0} + (magB[bitIdx] ? {32'b0, magA} : 64'b0);
    assign remShift = {acc[63:32], magA[bitIdx]};
    assign remDiff  = remShift - {1'b0, magB};
    assign divStep  = remDiff[32] ? {remShift[31:0], acc[30:0], 1'b0}
                                  : {remDiff[31:0],  acc[30:0], 1'b1};

    // Sign correction of the raw magnitude result.
    logic [63:0] prodFix;
    logic [31:0] quotFix;
    logic [31:0] remFix;
    logic [31:0] loNext;
    logic [31:0] hiNext;
    assign prodFix = (aNeg ^ bNeg) ? -acc : acc;
    assign quotFix = (aNeg ^ bNeg) ? -acc[31:0] : acc[31:0];
    assign remFix  = aNeg ? -acc[63:32] : acc[63:32];

    // Select the final lo/hi; divide by zero returns all-ones and the dividend.
    always_comb begin
        loNext = prodFix[31:0];
        hiNext = prodFix[63:32];
        if (isDiv) begin
            if (divZero) begin
                loNext = 32'hFFFF_FFFF;
                hiNext = aNeg ? -magA : magA;
            end else begin
                loNext = quotFix;
                hiNext = remFix;
            end
        end
    end

    // Control FSM with registered busy/done/lo/hi and the iteration datapath.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            lo      <= 32'b0;
            hi      <= 32'b0;
            count   <= 6'b0;
            acc     <= 64'b0;
            isDiv   <= 1'b0;
            aNeg    <= 1'b0;
            bNeg    <= 1'b0;
            divZero <= 1'b0;
            magA    <= 32'b0;
            magB    <= 32'b0;
        end else if (flush) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        isDiv   <= op[1];
                        aNeg    <= opSigned & srcA[31];
                        bNeg    <= opSigned & srcB[31];
                        divZero <= op[1] & (srcB == 32'b0);
                        magA    <= absA;
                        magB    <= absB;
                        count   <= 6'b0;
                        acc     <= 64'b0;
                        busy    <= 1'b1;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    acc   <= isDiv ? divStep : mulStep;
                    count <= count + 6'd1;
                    if (count == 6'd31) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    lo    <= loNext;
                    hi    <= hiNext;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed testbench for mul_div_unit: hand-computed products, quotients,
// latency, flush, reset and back-to-back behaviour.
module tb_mul_div_unit;

    localparam logic [1:0] MULT  = 2'b00;
    localparam logic [1:0] MULTU = 2'b01;
    localparam logic [1:0] DIV   = 2'b10;
    localparam logic [1:0] DIVU  = 2'b11;

    logic        clk;
    logic        resetN;
    logic        start;
    logic [1:0]  op;
    logic [31:0] srcA;
    logic [31:0] srcB;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] lo;
    logic [31:0] hi;

    int assertCount;
    int failCount;

    mul_div_unit dut (
        .clk    (clk),
        .resetN (resetN),
        .start  (start),
        .op     (op),
        .srcA   (srcA),
        .srcB   (srcB),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .lo     (lo),
        .hi     (hi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkEq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    // Issue a start in the current cycle; returns #1 after the sampling edge (cycle 1).
    task automatic doStart(input string tag, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        op    = o;
        srcA  = a;
        srcB  = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        checkEq({tag, ".busyC1"}, {31'b0, busy}, 32'd1);
    endtask

    // From cycle 1, step to cycle 34 and check the exact done timing and result.
    task automatic runToDone(input string tag, input logic [31:0] expLo, input logic [31:0] expHi);
        for (int c = 2; c <= 34; c++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (c == 33) begin
                checkEq({tag, ".busyC33"}, {31'b0, busy}, 32'd1);
                checkEq({tag, ".doneC33"}, {31'b0, done}, 32'd0);
            end
        end
        checkEq({tag, ".done"}, {31'b0, done}, 32'd1);
        checkEq({tag, ".busyDone"}, {31'b0, busy}, 32'd0);
        checkEq({tag, ".lo"}, lo, expLo);
        checkEq({tag, ".hi"}, hi, expHi);
    endtask

    // Watch a window of cycles and require that no done pulse appears.
    task automatic expectNoDone(input string tag, input int cycles);
        int dn;
        dn = 0;
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk);
            #1;
            if (done) dn++;
        end
        checkEq({tag, ".noDone"}, dn, 32'd0);
    endtask

    initial begin
        assertCount = 0;
        failCount   = 0;
        resetN = 1'b0;
        start  = 1'b0;
        op     = MULT;
        srcA   = 32'b0;
        srcB   = 32'b0;
        flush  = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        checkEq("rst.busy", {31'b0, busy}, 32'd0);
        checkEq("rst.done", {31'b0, done}, 32'd0);
        checkEq("rst.lo", lo, 32'd0);
        checkEq("rst.hi", hi, 32'd0);
        resetN = 1'b1;

        // Signed and unsigned multiply
        doStart("mult", MULT, 32'hFFFF_FFFF, 32'h0000_0002);
        runToDone("mult", 32'hFFFF_FFFE, 32'hFFFF_FFFF);
        @(posedge clk);
        #1;
        checkEq("mult.donePulse", {31'b0, done}, 32'd0);
        checkEq("mult.loHold", lo, 32'hFFFF_FFFE);

        doStart("multu", MULTU, 32'hFFFF_FFFF, 32'h0000_0002);
        runToDone("multu", 32'hFFFF_FFFE, 32'h0000_0001);
        doStart("multMin", MULT, 32'h8000_0000, 32'h8000_0000);
        runToDone("multMin", 32'h0000_0000, 32'h4000_0000);
        doStart("multuMax", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        runToDone("multuMax", 32'h0000_0001, 32'hFFFF_FFFE);

        // Signed / unsigned divide, divide by zero and overflow case
        doStart("divNeg", DIV, 32'hFFFF_FFF9, 32'h0000_0002);
        runToDone("divNeg", 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        doStart("divNegB", DIV, 32'h0000_0007, 32'hFFFF_FFFE);
        runToDone("divNegB", 32'hFFFF_FFFD, 32'h0000_0001);
        doStart("divuZero", DIVU, 32'h0000_0007, 32'h0000_0000);
        runToDone("divuZero", 32'hFFFF_FFFF, 32'h0000_0007);
        doStart("divZero", DIV, 32'hFFFF_FFF9, 32'h0000_0000);
        runToDone("divZero", 32'hFFFF_FFFF, 32'hFFFF_FFF9);
        doStart("divOvf", DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        runToDone("divOvf", 32'h8000_0000, 32'h0000_0000);

        // Start while busy is ignored
        doStart("ign", MULTU, 32'd6, 32'd7);
        start = 1'b1;
        op    = DIVU;
        srcA  = 32'd1;
        srcB  = 32'd1;
        runToDone("ign", 32'd42, 32'd0);

        // Flush mid-operation: no done, lo/hi keep the previous result
        doStart("flush", DIVU, 32'd100, 32'd7);
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        checkEq("flush.busy", {31'b0, busy}, 32'd0);
        checkEq("flush.lo", lo, 32'd42);
        checkEq("flush.hi", hi, 32'd0);
        expectNoDone("flush", 40);
        checkEq("flush.loKeep", lo, 32'd42);

        // flush and start together in IDLE: flush wins
        start = 1'b1;
        op    = MULTU;
        srcA  = 32'd2;
        srcB  = 32'd2;
        flush = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
        checkEq("flushStart.busy", {31'b0, busy}, 32'd0);
        expectNoDone("flushStart", 40);

        // Reset mid-operation at cycle 20, then start on the first edge out of reset
        doStart("rstMid", MULTU, 32'd3, 32'd5);
        repeat (18) @(posedge clk);
        #1;
        resetN = 1'b0;
        @(posedge clk);
        #1;
        checkEq("rstMid.busy", {31'b0, busy}, 32'd0);
        checkEq("rstMid.lo", lo, 32'd0);
        checkEq("rstMid.hi", hi, 32'd0);
        resetN = 1'b1;
        doStart("afterRst", MULTU, 32'd3, 32'd5);
        runToDone("afterRst", 32'd15, 32'd0);

        // Back-to-back: start in the done cycle
        doStart("b2b", DIVU, 32'd100, 32'd7);
        runToDone("b2b", 32'd14, 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time bound");
        $fatal(1, "timeout");
    end

endmodule
